// File: rtl/cordic_angle_reduce.sv
// Range reduction front end for a first-quadrant CORDIC sin/cos core.
// Folds a signed Q10.14 angle into [0, pi/2) and tells the core what to compute and whether to negate.
module cordic_angle_reduce #(
  parameter int HALF_PI = 25736
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] angle_in,
  input  logic        trig_mode_in,
  input  logic        dn_idle,
  output logic        busy,
  output logic [15:0] theta_out,
  output logic        trig_mode_out,
  output logic        negate_out,
  output logic        init_out,
  output logic        calc_out
);

  typedef enum logic [2:0] {IDLE, REDUCE, FOLD, INIT, CALC} state_t;

  typedef struct packed {
    logic        neg;
    logic        mode;
    logic [24:0] a;
  } req_t;

  localparam logic [31:0] Q1     = 32'(HALF_PI);
  localparam logic [31:0] Q2     = 32'(2 * HALF_PI);
  localparam logic [31:0] Q3     = 32'(3 * HALF_PI);
  localparam logic [31:0] TWO_PI = 32'(4 * HALF_PI);

  state_t      state, state_nxt;
  req_t        req;
  logic [2:0]  k;
  logic [31:0] a_ext, step, qh;
  logic [1:0]  q;
  logic        qneg;

  assign a_ext = {7'd0, req.a};
  // Binary long-division style reduction: subtract 2pi*2^k for k = 7..0.
  assign step  = TWO_PI << k;

  always_comb begin
    q = 2'd0;
    if      (a_ext >= Q3) q = 2'd3;
    else if (a_ext >= Q2) q = 2'd2;
    else if (a_ext >= Q1) q = 2'd1;
  end

  assign qh   = 32'(q) * Q1;
  // sin negates in quadrants 2,3; cos in quadrants 1,2.
  assign qneg = req.mode ? q[1] : (q[1] ^ q[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = REDUCE;
      REDUCE:  if (k == 3'd0) state_nxt = FOLD;
      FOLD:    state_nxt = INIT;
      INIT:    if (dn_idle) state_nxt = CALC;
      CALC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign init_out = (state == INIT) && dn_idle;
  assign calc_out = (state == CALC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req           <= '0;
      k             <= 3'd0;
      theta_out     <= 16'd0;
      trig_mode_out <= 1'b0;
      negate_out    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          req.neg  <= angle_in[23];
          req.mode <= trig_mode_in;
          // 25-bit magnitude so the most negative input does not overflow.
          req.a    <= angle_in[23] ? (25'd0 - {angle_in[23], angle_in}) : {1'b0, angle_in};
          k        <= 3'd7;
        end
        REDUCE: begin
          if (a_ext >= step) req.a <= 25'(a_ext - step);
          k <= k - 3'd1;
        end
        FOLD: begin
          theta_out     <= 16'(a_ext - qh);
          trig_mode_out <= req.mode ^ q[0];
          negate_out    <= qneg ^ (req.neg & req.mode);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_angle_reduce.sv
// Randomized and directed bench for cordic_angle_reduce against a modulo-arithmetic reference model.
module tb_cordic_angle_reduce;

  localparam int HP = 25736;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] angle_in = '0;
  logic        trig_mode_in = 1'b0;
  logic        dn_idle = 1'b1;
  logic        busy, trig_mode_out, negate_out, init_out, calc_out;
  logic [15:0] theta_out;

  int checks = 0;
  int failures = 0;

  cordic_angle_reduce #(.HALF_PI(HP)) dut (
    .clk(clk), .rst(rst), .start(start), .angle_in(angle_in),
    .trig_mode_in(trig_mode_in), .dn_idle(dn_idle), .busy(busy),
    .theta_out(theta_out), .trig_mode_out(trig_mode_out),
    .negate_out(negate_out), .init_out(init_out), .calc_out(calc_out)
  );

  always #5 clk = ~clk;

  // Reference: |angle| mod 2pi, quadrant by integer division, sign from trig identities.
  function automatic void model(input logic [23:0] ang, input logic md,
                                output logic [15:0] th, output logic tm, output logic ng);
    int s, a, q;
    logic sneg;
    s    = int'($signed(ang));
    sneg = (s < 0);
    a    = sneg ? -s : s;
    a    = a % (4 * HP);
    q    = a / HP;
    th   = 16'(a - q * HP);
    tm   = md ^ q[0];
    ng   = (md ? (q >= 2) : (q == 1 || q == 2)) ^ (sneg & md);
  endfunction

  task automatic run_op(input string name, input logic [23:0] ang, input logic md);
    logic [15:0] eth;
    logic etm, eng;
    model(ang, md, eth, etm, eng);
    @(negedge clk);
    angle_in = ang; trig_mode_in = md; start = 1'b1; dn_idle = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc <= 11; cyc++) begin
      checks++;
      if ({busy, init_out, calc_out} !== {cyc <= 10, cyc == 9, cyc == 10}) begin
        failures++;
        $display("FAIL %s_timing cyc=%0d got busy/init/calc=%b exp=%b", name, cyc,
                 {busy, init_out, calc_out}, {cyc <= 10, cyc == 9, cyc == 10});
      end
      if (cyc < 11) begin @(posedge clk); #1; end
    end
    checks++;
    if ({theta_out, trig_mode_out, negate_out} !== {eth, etm, eng}) begin
      failures++;
      $display("FAIL %s_result ang=%h md=%b got theta=%0d tm=%b ng=%b exp theta=%0d tm=%b ng=%b",
               name, ang, md, theta_out, trig_mode_out, negate_out, eth, etm, eng);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, theta_out, trig_mode_out, negate_out, init_out, calc_out} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {busy, theta_out, trig_mode_out, negate_out, init_out, calc_out});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op("half_pi_sin",     24'd25736, 1'b1);
    run_op("neg_half_pi_sin", 24'(-25736), 1'b1);
    run_op("neg_half_pi_cos", 24'(-25736), 1'b0);
    run_op("q3_plus100_cos",  24'd77308, 1'b0);
    run_op("two_pi_sin",      24'd102944, 1'b1);
    run_op("most_neg_cos",    24'h800000, 1'b0);
  endtask

  task automatic test_boundaries();
    logic [23:0] b [10];
    b = '{24'd0, 24'(HP), 24'(2*HP), 24'(3*HP), 24'(4*HP), 24'(4*HP-1),
          24'(4*HP*128), 24'h7fffff, 24'(-4*HP), 24'(-3*HP)};
    for (int i = 0; i < 10; i++) begin
      run_op("boundary_sin", b[i], 1'b1);
      run_op("boundary_cos", b[i], 1'b0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op("random", 24'($urandom), 1'($urandom));
  endtask

  task automatic test_dn_stall();
    logic [15:0] eth;
    logic etm, eng;
    model(24'd30000, 1'b0, eth, etm, eng);
    @(negedge clk);
    angle_in = 24'd30000; trig_mode_in = 1'b0; start = 1'b1; dn_idle = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; angle_in = 24'd12345;
      checks++;
      if ({busy, init_out, calc_out} !== 3'b100) begin
        failures++;
        $display("FAIL stall_hold i=%0d got busy/init/calc=%b exp=100", i, {busy, init_out, calc_out});
      end
      @(posedge clk); #1;
    end
    @(negedge clk); start = 1'b0; dn_idle = 1'b1;
    #1;
    checks++;
    if ({busy, init_out, calc_out} !== 3'b110) begin
      failures++;
      $display("FAIL stall_init got busy/init/calc=%b exp=110", {busy, init_out, calc_out});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, init_out, calc_out} !== 3'b101) begin
      failures++;
      $display("FAIL stall_calc got busy/init/calc=%b exp=101", {busy, init_out, calc_out});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, init_out, calc_out, theta_out, trig_mode_out, negate_out} !== {3'b000, eth, etm, eng}) begin
      failures++;
      $display("FAIL stall_done got=%h exp=%h", {busy, init_out, calc_out, theta_out, trig_mode_out, negate_out},
               {3'b000, eth, etm, eng});
    end
  endtask

  task automatic test_reset_mid();
    run_op("pre_reset", 24'd40000, 1'b1);
    @(negedge clk);
    angle_in = 24'd60000; trig_mode_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, theta_out, trig_mode_out, negate_out, init_out, calc_out} !== 21'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h exp=0",
               {busy, theta_out, trig_mode_out, negate_out, init_out, calc_out});
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, init_out, calc_out} !== 3'b000) begin
        failures++;
        $display("FAIL reset_mid_quiet i=%0d got busy/init/calc=%b exp=000", i, {busy, init_out, calc_out});
      end
    end
    run_op("after_reset", 24'd60000, 1'b0);
  endtask

  task automatic test_busy_ignore();
    logic [15:0] eth;
    logic etm, eng;
    model(24'd70000, 1'b1, eth, etm, eng);
    @(negedge clk);
    angle_in = 24'd70000; trig_mode_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc <= 11; cyc++) begin
      start    = (cyc >= 2 && cyc <= 5) || cyc == 10;
      angle_in = 24'd5000; trig_mode_in = 1'b0;
      checks++;
      if ({busy, init_out, calc_out} !== {cyc <= 10, cyc == 9, cyc == 10}) begin
        failures++;
        $display("FAIL busy_ignore_timing cyc=%0d got=%b exp=%b", cyc,
                 {busy, init_out, calc_out}, {cyc <= 10, cyc == 9, cyc == 10});
      end
      if (cyc == 10) start = 1'b0;
      if (cyc < 11) begin @(posedge clk); #1; end
    end
    checks++;
    if ({theta_out, trig_mode_out, negate_out} !== {eth, etm, eng}) begin
      failures++;
      $display("FAIL busy_ignore_result got theta=%0d tm=%b ng=%b exp theta=%0d tm=%b ng=%b",
               theta_out, trig_mode_out, negate_out, eth, etm, eng);
    end
    run_op("after_ignore", 24'd5000, 1'b0);
  endtask

  task automatic test_hold();
    logic [15:0] eth;
    logic etm, eng;
    model(24'd90000, 1'b1, eth, etm, eng);
    run_op("hold_first", 24'd90000, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({theta_out, trig_mode_out, negate_out} !== {eth, etm, eng}) begin
      failures++;
      $display("FAIL hold_idle got=%h exp=%h", {theta_out, trig_mode_out, negate_out}, {eth, etm, eng});
    end
    @(negedge clk);
    angle_in = 24'd10; trig_mode_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if ({theta_out, trig_mode_out, negate_out} !== {eth, etm, eng}) begin
      failures++;
      $display("FAIL hold_reduce got=%h exp=%h", {theta_out, trig_mode_out, negate_out}, {eth, etm, eng});
    end
    repeat (5) @(posedge clk);
    #1;
    model(24'd10, 1'b0, eth, etm, eng);
    checks++;
    if ({busy, theta_out, trig_mode_out, negate_out} !== {1'b0, eth, etm, eng}) begin
      failures++;
      $display("FAIL hold_second got=%h exp=%h", {busy, theta_out, trig_mode_out, negate_out},
               {1'b0, eth, etm, eng});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundaries();
    test_random();
    test_dn_stall();
    test_reset_mid();
    test_busy_ignore();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
